// File: rtl/uio_bus_arbiter.sv
// rtl/uio_bus_arbiter.sv - two-requester arbiter sharing one bidirectional 8-bit UIO pad bus
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   ena                            permits new grants (never aborts a running transaction)
//   r0_*/r1_* req,we,addr,wdata    requester transaction inputs, held until ack
//   r0_ack, r1_ack                 one-cycle completion pulse to the granted requester
//   rdata                          last captured read data, shared by both requesters
//   busy                           high whenever the engine is not idle
//   uio_in, uio_out, uio_oe        pad input, pad output, pad enables (all-ones or all-zeros)
//   bus_strb, bus_we               address strobe and direction qualifier to the device
module uio_bus_arbiter #(
    parameter int TURN_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       r0_req,
    input  logic       r1_req,
    input  logic       r0_we,
    input  logic       r1_we,
    input  logic [7:0] r0_addr,
    input  logic [7:0] r1_addr,
    input  logic [7:0] r0_wdata,
    input  logic [7:0] r1_wdata,
    output logic       r0_ack,
    output logic       r1_ack,
    output logic [7:0] rdata,
    output logic       busy,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    output logic       bus_strb,
    output logic       bus_we
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WDATA,
        S_TURN,
        S_RDATA,
        S_DONE
    } state_t;

    localparam logic [3:0] TURN_LOAD = 4'(TURN_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] turn_cnt_q, turn_cnt_d;
    logic       last_r1_q;
    logic       lat_r1_q;
    logic       lat_we_q;
    logic [7:0] lat_addr_q;
    logic [7:0] lat_wdata_q;

    logic       gnt_r1;
    logic       grant_en;
    logic       sel_we;
    logic [7:0] sel_addr;
    logic [7:0] sel_wdata;

    logic [7:0] uio_out_d;
    logic [7:0] uio_oe_d;
    logic       bus_strb_d;
    logic       bus_we_d;
    logic       r0_ack_d;
    logic       r1_ack_d;

    // On a tie the requester not served last wins; a lone request always wins.
    assign gnt_r1    = (r0_req && r1_req) ? ~last_r1_q : r1_req;
    assign sel_we    = gnt_r1 ? r1_we    : r0_we;
    assign sel_addr  = gnt_r1 ? r1_addr  : r0_addr;
    assign sel_wdata = gnt_r1 ? r1_wdata : r0_wdata;

    // Every output is computed here for the *next* state and registered, so
    // what appears on the pins in a state is already held in flops.
    always_comb begin
        state_d    = state_q;
        turn_cnt_d = turn_cnt_q;
        grant_en   = 1'b0;
        uio_out_d  = 8'h00;
        uio_oe_d   = 8'h00;
        bus_strb_d = 1'b0;
        bus_we_d   = 1'b0;
        r0_ack_d   = 1'b0;
        r1_ack_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ena && (r0_req || r1_req)) begin
                    grant_en   = 1'b1;
                    state_d    = S_ADDR;
                    uio_oe_d   = 8'hFF;
                    uio_out_d  = sel_addr;
                    bus_strb_d = 1'b1;
                    bus_we_d   = sel_we;
                end
            end
            S_ADDR: begin
                if (lat_we_q) begin
                    state_d   = S_WDATA;
                    uio_oe_d  = 8'hFF;
                    uio_out_d = lat_wdata_q;
                    bus_we_d  = 1'b1;
                end else begin
                    state_d    = S_TURN;
                    turn_cnt_d = TURN_LOAD;
                end
            end
            S_WDATA: begin
                state_d  = S_DONE;
                r0_ack_d = ~lat_r1_q;
                r1_ack_d = lat_r1_q;
            end
            S_TURN: begin
                if (turn_cnt_q == 4'd0) begin
                    state_d = S_RDATA;
                end else begin
                    turn_cnt_d = turn_cnt_q - 4'd1;
                end
            end
            S_RDATA: begin
                state_d  = S_DONE;
                r0_ack_d = ~lat_r1_q;
                r1_ack_d = lat_r1_q;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            turn_cnt_q  <= 4'd0;
            last_r1_q   <= 1'b1;
            lat_r1_q    <= 1'b0;
            lat_we_q    <= 1'b0;
            lat_addr_q  <= 8'h00;
            lat_wdata_q <= 8'h00;
            uio_out     <= 8'h00;
            uio_oe      <= 8'h00;
            bus_strb    <= 1'b0;
            bus_we      <= 1'b0;
            r0_ack      <= 1'b0;
            r1_ack      <= 1'b0;
            rdata       <= 8'h00;
            busy        <= 1'b0;
        end else begin
            state_q    <= state_d;
            turn_cnt_q <= turn_cnt_d;
            if (grant_en) begin
                last_r1_q   <= gnt_r1;
                lat_r1_q    <= gnt_r1;
                lat_we_q    <= sel_we;
                lat_addr_q  <= sel_addr;
                lat_wdata_q <= sel_wdata;
            end
            uio_out  <= uio_out_d;
            uio_oe   <= uio_oe_d;
            bus_strb <= bus_strb_d;
            bus_we   <= bus_we_d;
            r0_ack   <= r0_ack_d;
            r1_ack   <= r1_ack_d;
            busy     <= (state_d != S_IDLE);
            // The pad value present during the RDATA cycle is what the device returned.
            if (state_q == S_RDATA) begin
                rdata <= uio_in;
            end
        end
    end

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// tb/tb_uio_bus_arbiter.sv - randomized and directed bench for uio_bus_arbiter against a transaction-level model
module tb_uio_bus_arbiter;

    localparam int TC = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       r0_req, r1_req;
    logic       r0_we, r1_we;
    logic [7:0] r0_addr, r1_addr;
    logic [7:0] r0_wdata, r1_wdata;
    logic       r0_ack, r1_ack;
    logic [7:0] rdata;
    logic       busy;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic       bus_strb;
    logic       bus_we;

    uio_bus_arbiter #(.TURN_CYCLES(TC)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .r0_req(r0_req), .r1_req(r1_req),
        .r0_we(r0_we), .r1_we(r1_we),
        .r0_addr(r0_addr), .r1_addr(r1_addr),
        .r0_wdata(r0_wdata), .r1_wdata(r1_wdata),
        .r0_ack(r0_ack), .r1_ack(r1_ack),
        .rdata(rdata), .busy(busy),
        .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe),
        .bus_strb(bus_strb), .bus_we(bus_we)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One expected bus cycle. out_v/we_v mark cycles where uio_out/bus_we are defined.
    typedef struct packed {
        logic [7:0] oe;
        logic [7:0] out;
        logic       out_v;
        logic       strb;
        logic       we;
        logic       we_v;
        logic       ack0;
        logic       ack1;
        logic       rd;
    } exp_t;

    exp_t       q[$];
    exp_t       cur;
    logic       cur_idle;
    logic       m_last_r1;
    logic [7:0] m_rdata;

    function automatic exp_t mk(input logic [7:0] oe, input logic [7:0] out, input logic out_v,
                                input logic strb, input logic we, input logic we_v,
                                input logic a0, input logic a1, input logic rd);
        exp_t e;
        e.oe = oe; e.out = out; e.out_v = out_v; e.strb = strb; e.we = we; e.we_v = we_v;
        e.ack0 = a0; e.ack1 = a1; e.rd = rd;
        return e;
    endfunction

    // Builds the whole cycle sequence of a transaction at grant time.
    task automatic model_advance();
        logic [7:0] rd_next;
        logic       w1, we;
        logic [7:0] a, d;
        if (!rst_n) begin
            q.delete();
            cur       = mk(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            cur_idle  = 1'b1;
            m_last_r1 = 1'b1;
            m_rdata   = 8'h00;
            return;
        end
        rd_next = cur.rd ? uio_in : m_rdata;
        if (cur_idle && ena && (r0_req || r1_req)) begin
            w1 = (r0_req && r1_req) ? !m_last_r1 : r1_req;
            m_last_r1 = w1;
            we = w1 ? r1_we : r0_we;
            a  = w1 ? r1_addr : r0_addr;
            d  = w1 ? r1_wdata : r0_wdata;
            q.push_back(mk(8'hFF, a, 1'b1, 1'b1, we, 1'b1, 1'b0, 1'b0, 1'b0));
            if (we) begin
                q.push_back(mk(8'hFF, d, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
            end else begin
                for (int i = 0; i < TC; i++)
                    q.push_back(mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
                q.push_back(mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
            end
            q.push_back(mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, !w1, w1, 1'b0));
        end
        if (q.size() > 0) begin
            cur      = q.pop_front();
            cur_idle = 1'b0;
        end else begin
            cur      = mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            cur_idle = 1'b1;
        end
        m_rdata = rd_next;
    endtask

    // Inputs for this cycle are already driven; advance one clock and compare.
    task automatic step();
        model_advance();
        @(posedge clk);
        #1;
        chk("uio_oe", uio_oe, cur.oe);
        chk("bus_strb", bus_strb, cur.strb);
        chk("r0_ack", r0_ack, cur.ack0);
        chk("r1_ack", r1_ack, cur.ack1);
        chk("busy", busy, !cur_idle);
        chk("rdata", rdata, m_rdata);
        if (cur.out_v) chk("uio_out", uio_out, cur.out);
        if (cur.we_v)  chk("bus_we", bus_we, cur.we);
    endtask

    int         grants[$];
    int         gap;
    logic       seen_strb;
    int         cnt;
    logic       pend0, pend1;

    initial begin
        rst_n = 1'b0; ena = 1'b0;
        r0_req = 0; r1_req = 0; r0_we = 0; r1_we = 0;
        r0_addr = 0; r1_addr = 0; r0_wdata = 0; r1_wdata = 0; uio_in = 0;
        cur = mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cur_idle = 1'b1; m_last_r1 = 1'b1; m_rdata = 8'h00;
        #1;
        step(); step();
        chk("rst_uio_out", uio_out, 8'h00);
        chk("rst_bus_we", bus_we, 1'b0);
        rst_n = 1'b1; ena = 1'b1;
        step();

        // r0 write 3C/A5
        r0_req = 1; r0_we = 1; r0_addr = 8'h3C; r0_wdata = 8'hA5;
        step();
        chk("w_addr_out", uio_out, 8'h3C); chk("w_addr_strb", bus_strb, 1'b1); chk("w_addr_oe", uio_oe, 8'hFF);
        r0_addr = 8'h77; r0_wdata = 8'h11; r0_we = 0;
        step();
        chk("w_data_out", uio_out, 8'hA5); chk("w_data_we", bus_we, 1'b1);
        step();
        chk("w_done_oe", uio_oe, 8'h00); chk("w_done_ack", r0_ack, 1'b1);
        r0_req = 0;
        step();

        // r1 read 10 with TURN_CYCLES=2, device returns 5A
        r1_req = 1; r1_we = 0; r1_addr = 8'h10; uio_in = 8'h5A;
        step();
        step(); chk("r_turn1_oe", uio_oe, 8'h00);
        step(); chk("r_turn2_oe", uio_oe, 8'h00);
        step();
        step(); chk("r_ack", r1_ack, 1'b1); chk("r_rdata", rdata, 8'h5A);
        r1_req = 0;
        step();

        // both requesters hold reads from reset: alternation and bus gaps
        rst_n = 0; step(); rst_n = 1;
        r0_req = 1; r1_req = 1; r0_we = 0; r1_we = 0; r0_addr = 8'h20; r1_addr = 8'h21;
        gap = 0; seen_strb = 0; cnt = 0;
        while (grants.size() < 4 && cnt < 60) begin
            uio_in = 8'($urandom);
            step();
            cnt++;
            if (r0_ack) grants.push_back(0);
            if (r1_ack) grants.push_back(1);
            if (bus_strb) begin
                if (seen_strb) chk("b2b_gap", (gap >= 2), 1'b1);
                seen_strb = 1; gap = 0;
            end else if (uio_oe == 8'h00) gap++;
        end
        chk("b2b_count", grants.size(), 4);
        for (int i = 0; i < grants.size(); i++) chk("b2b_order", grants[i], i % 2);
        r0_req = 0; r1_req = 0;
        cnt = 0;
        while (busy && cnt < 20) begin step(); cnt++; end
        step();

        // ena low blocks grants only
        ena = 0; r0_req = 1; r0_we = 1; r0_addr = 8'h44; r0_wdata = 8'h55;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("ena0_busy", busy, 1'b0); chk("ena0_oe", uio_oe, 8'h00); chk("ena0_ack", r0_ack, 1'b0);
        end
        ena = 1;
        step();
        chk("ena1_grant", bus_strb, 1'b1);
        cnt = 0;
        while (!r0_ack && cnt < 10) begin step(); cnt++; end
        chk("ena1_ack", r0_ack, 1'b1);
        r0_req = 0;
        step();

        // reset during TURN, then the same request re-issues
        r0_req = 1; r0_we = 0; r0_addr = 8'h66;
        step(); step();
        rst_n = 0;
        step();
        chk("rt_oe", uio_oe, 8'h00); chk("rt_out", uio_out, 8'h00); chk("rt_strb", bus_strb, 1'b0);
        chk("rt_we", bus_we, 1'b0); chk("rt_ack", {r0_ack, r1_ack}, 2'b00);
        chk("rt_rdata", rdata, 8'h00); chk("rt_busy", busy, 1'b0);
        rst_n = 1;
        cnt = 0;
        while (!r0_ack && cnt < 12) begin step(); cnt++; end
        chk("rt_latency", cnt, 3 + TC);
        r0_req = 0;
        step();

        // randomized traffic
        pend0 = 0; pend1 = 0;
        for (int k = 0; k < 4000; k++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            ena   = ($urandom_range(0, 9) < 8);
            uio_in = 8'($urandom);
            if (!pend0 && $urandom_range(0, 2) == 0) pend0 = 1;
            if (!pend1 && $urandom_range(0, 2) == 0) pend1 = 1;
            if (pend0 && $urandom_range(0, 99) == 0) pend0 = 0;
            if (pend1 && $urandom_range(0, 99) == 0) pend1 = 0;
            r0_req = pend0; r1_req = pend1;
            r0_we = 1'($urandom); r1_we = 1'($urandom);
            r0_addr = 8'($urandom); r1_addr = 8'($urandom);
            r0_wdata = 8'($urandom); r1_wdata = 8'($urandom);
            step();
            if (r0_ack) pend0 = 0;
            if (r1_ack) pend1 = 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uio_bus_arbiter.md
UIO_BUS_ARBITER -- requirements
Module: uio_bus_arbiter

Interface
REQ-001 Parameter TURN_CYCLES, default 1: number of bus-released turnaround cycles between the address phase and the read-sample phase; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 ena  input  1  high enables new grants; low blocks grants only.
REQ-005 r0_req, r1_req  input  1 each  transaction request; requester holds it high until it samples its ack high.
REQ-006 r0_we, r1_we  input  1 each  1 = write, 0 = read; valid while req is high.
REQ-007 r0_addr, r1_addr  input  8 each  byte address; valid while req is high.
REQ-008 r0_wdata, r1_wdata  input  8 each  write data; valid while req is high.
REQ-009 r0_ack, r1_ack  output  1 each  one-cycle completion pulse to the granted requester.
REQ-010 rdata  output  8  read data, shared by both requesters.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 uio_in  input  8  pad input path.
REQ-013 uio_out  output  8  pad output path.
REQ-014 uio_oe  output  8  pad enables, 1 = drive; always all-ones or all-zeros.
REQ-015 bus_strb  output  1  address strobe to the external device.
REQ-016 bus_we  output  1  direction qualifier to the external device.

Function
REQ-017 All outputs are driven directly from flops, with no combinational path from any input to any output.
REQ-018 States are IDLE, ADDR, WDATA, TURN, RDATA and DONE.
REQ-019 IDLE: uio_oe=00, bus_strb=0; with ena=1 and any req high, grant one requester, latch its we/addr/wdata, and go to ADDR.
REQ-020 Arbitration: a single request wins; if both requests are high, grant the requester not granted last; the last-grant flag resets to r1, so r0 wins the first tie.
REQ-021 ADDR lasts 1 cycle: uio_oe=FF, uio_out=latched addr, bus_strb=1, bus_we=latched we; next state is WDATA if we=1, else TURN.
REQ-022 WDATA lasts 1 cycle: uio_oe=FF, uio_out=latched wdata, bus_strb=0, bus_we=1; next state is DONE.
REQ-023 TURN lasts exactly TURN_CYCLES cycles: uio_oe=00, bus_strb=0, bus_we=0; a 4-bit down-counter loaded on ADDR exit; next state is RDATA.
REQ-024 RDATA lasts 1 cycle: uio_oe=00; uio_in is captured into rdata at the end of the cycle; next state is DONE.
REQ-025 DONE lasts 1 cycle: uio_oe=00; the granted requester's ack=1 and the other ack=0; next state is IDLE.
REQ-026 rdata holds its value until the next RDATA capture; writes leave rdata unchanged.
REQ-027 Latency, request first sampled in IDLE at cycle T: write gives ADDR at T+1, WDATA at T+2, ack at T+3; read gives ack at T+3+TURN_CYCLES.
REQ-028 The bus is never driven in two consecutive transactions without an intervening uio_oe=00 cycle (DONE plus IDLE guarantee this).
REQ-029 ena falling mid-transaction does not abort; the transaction completes normally and no new grant is made while ena=0.
REQ-030 A req dropped before ack is a requester protocol violation; the latched transaction still completes and acks.
REQ-031 Latched we/addr/wdata are immune to requester input changes after the grant.

Reset
REQ-032 On a rising edge with rst_n=0 (synchronous reset): state=IDLE; uio_oe=00, uio_out=00, bus_strb=0, bus_we=0, r0_ack=r1_ack=0, rdata=00, busy=0, last-grant=r1, TURN counter=0.
REQ-033 Reset applied in any state aborts the transaction with no ack issued; arbitration restarts from IDLE on the first edge with rst_n=1.

Verification
REQ-034 r0 write, addr=3C, wdata=A5, ena=1 -> uio_out=3C with strb=1 and oe=FF at T+1; A5 with we=1 at T+2; oe=00 and r0_ack=1 at T+3.
REQ-035 r1 read, addr=10, TURN_CYCLES=2, uio_in=5A during RDATA -> oe=00 at T+2..T+3; r1_ack=1 and rdata=5A at T+5.
REQ-036 r0 and r1 held high for back-to-back reads from reset -> grants alternate r0, r1, r0, r1, and uio_oe=00 for at least 2 cycles between ADDR phases.
REQ-037 ena=0 with r0_req=1 for 10 cycles -> busy=0, oe=00, no ack; ena=1 -> grant on the next edge.
REQ-038 rst_n=0 during TURN -> next cycle all outputs at reset values and no ack; the same request re-issues a full transaction after release.
